eight_bit_full_adder: RTL and testbench

//   8-bit arithmetic/logic unit built from ripple full-adder cells. From operands a and b it

---
 rtl/eight_bit_full_adder.sv | 136 +++++++++++++
 tb/tb_eight_bit_full_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/eight_bit_full_adder.sv
// Registered 8-bit add/subtract/xor/shift unit built from ripple full-adder cells.
// Optional macro SIGNED_FLAGS_EN adds registered add_ovf, sub_ovf and zero outputs.

module efa_full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

module eight_bit_full_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       cout,
  output logic [7:0] difference,
  output logic       bout,
  output logic [7:0] xor_output,
  output logic [7:0] left_shift
`ifdef SIGNED_FLAGS_EN
  ,
  output logic       add_ovf,
  output logic       sub_ovf,
  output logic       zero
`endif
);
  logic [8:0] add_c;
  logic [8:0] sub_c;
  logic [7:0] add_s;
  logic [7:0] sub_s;
  logic [7:0] b_n;

  // Subtraction reuses the adder structure: a + ~b + 1.
  assign add_c[0] = 1'b0;
  assign sub_c[0] = 1'b1;
  assign b_n      = ~b;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      efa_full_adder_cell u_add (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (add_c[gi]),
        .s    (add_s[gi]),
        .cout (add_c[gi+1])
      );
      efa_full_adder_cell u_sub (
        .a    (a[gi]),
        .b    (b_n[gi]),
        .cin  (sub_c[gi]),
        .s    (sub_s[gi]),
        .cout (sub_c[gi+1])
      );
    end
  endgenerate

  logic [7:0] sum_d, sum_q;
  logic       cout_d, cout_q;
  logic [7:0] difference_d, difference_q;
  logic       bout_d, bout_q;
  logic [7:0] xor_output_d, xor_output_q;
  logic [7:0] left_shift_d, left_shift_q;

  always_comb begin
    sum_d        = add_s;
    cout_d       = add_c[8];
    difference_d = sub_s;
    bout_d       = ~sub_c[8];
    xor_output_d = a ^ b;
    left_shift_d = {a[6:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q        <= 8'd0;
      cout_q       <= 1'b0;
      difference_q <= 8'd0;
      bout_q       <= 1'b0;
      xor_output_q <= 8'd0;
      left_shift_q <= 8'd0;
    end else begin
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      difference_q <= difference_d;
      bout_q       <= bout_d;
      xor_output_q <= xor_output_d;
      left_shift_q <= left_shift_d;
    end
  end

  assign sum        = sum_q;
  assign cout       = cout_q;
  assign difference = difference_q;
  assign bout       = bout_q;
  assign xor_output = xor_output_q;
  assign left_shift = left_shift_q;

`ifdef SIGNED_FLAGS_EN
  logic add_ovf_d, add_ovf_q;
  logic sub_ovf_d, sub_ovf_q;
  logic zero_d, zero_q;

  // Flags derive from the combinational results, so they align with the registered values.
  always_comb begin
    add_ovf_d = (a[7] == b[7]) && (add_s[7] != a[7]);
    sub_ovf_d = (a[7] != b[7]) && (sub_s[7] != a[7]);
    zero_d    = (add_s == 8'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_ovf_q <= 1'b0;
      sub_ovf_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      add_ovf_q <= add_ovf_d;
      sub_ovf_q <= sub_ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign add_ovf = add_ovf_q;
  assign sub_ovf = sub_ovf_q;
  assign zero    = zero_q;
`endif

endmodule

// File: tb/tb_eight_bit_full_adder.sv
// Directed and exhaustive bench for eight_bit_full_adder; flag checks need SIGNED_FLAGS_EN.

module tb_eight_bit_full_adder;
  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;
  logic       cout;
  logic [7:0] difference;
  logic       bout;
  logic [7:0] xor_output;
  logic [7:0] left_shift;
`ifdef SIGNED_FLAGS_EN
  logic       add_ovf;
  logic       sub_ovf;
  logic       zero;
`endif

  int compared;
  int mismatched;

  eight_bit_full_adder dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .sum        (sum),
    .cout       (cout),
    .difference (difference),
    .bout       (bout),
    .xor_output (xor_output),
    .left_shift (left_shift)
`ifdef SIGNED_FLAGS_EN
    ,
    .add_ovf    (add_ovf),
    .sub_ovf    (sub_ovf),
    .zero       (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent reference: widened arithmetic, not a bit-level chain.
  task automatic chk_all(input string tag, input logic [7:0] ra, input logic [7:0] rb);
    logic [8:0] s9;
    logic [8:0] d9;
    logic [7:0] ls;
    s9 = {1'b0, ra} + {1'b0, rb};
    d9 = {1'b0, ra} - {1'b0, rb};
    ls = ra << 1;
    chk({tag, ".sum"}, {1'b0, sum}, {1'b0, s9[7:0]});
    chk({tag, ".cout"}, {8'd0, cout}, {8'd0, s9[8]});
    chk({tag, ".diff"}, {1'b0, difference}, {1'b0, d9[7:0]});
    chk({tag, ".bout"}, {8'd0, bout}, {8'd0, d9[8]});
    chk({tag, ".xor"}, {1'b0, xor_output}, {1'b0, ra ^ rb});
    chk({tag, ".lshift"}, {1'b0, left_shift}, {1'b0, ls});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".sum"}, {1'b0, sum}, 9'd0);
    chk({tag, ".cout"}, {8'd0, cout}, 9'd0);
    chk({tag, ".diff"}, {1'b0, difference}, 9'd0);
    chk({tag, ".bout"}, {8'd0, bout}, 9'd0);
    chk({tag, ".xor"}, {1'b0, xor_output}, 9'd0);
    chk({tag, ".lshift"}, {1'b0, left_shift}, 9'd0);
`ifdef SIGNED_FLAGS_EN
    chk({tag, ".add_ovf"}, {8'd0, add_ovf}, 9'd0);
    chk({tag, ".sub_ovf"}, {8'd0, sub_ovf}, 9'd0);
    chk({tag, ".zero"}, {8'd0, zero}, 9'd0);
`endif
  endtask

  task automatic step(input logic [7:0] na, input logic [7:0] nb);
    a = na;
    b = nb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b0;
    a   = 8'hFF;
    b   = 8'h01;

    // Load nonzero values, then raise reset between edges.
    @(posedge clk);
    #1;
    step(8'hFF, 8'h01);
    chk("preload.sum", {1'b0, sum}, 9'd0);
    chk("preload.cout", {8'd0, cout}, 9'd1);
    chk("preload.diff", {1'b0, difference}, 9'd254);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("rst_held");
    rst = 1'b0;

    // First edge after release loads current operands.
    step(8'd200, 8'd100);
    chk("add_carry.sum", {1'b0, sum}, 9'd44);
    chk("add_carry.cout", {8'd0, cout}, 9'd1);
    chk("add_carry.xor", {1'b0, xor_output}, 9'h0AC);
    chk("add_carry.lshift", {1'b0, left_shift}, 9'd144);

    step(8'd5, 8'd10);
    chk("sub_borrow.diff", {1'b0, difference}, 9'd251);
    chk("sub_borrow.bout", {8'd0, bout}, 9'd1);

    step(8'd10, 8'd5);
    chk("sub_noborrow.diff", {1'b0, difference}, 9'd5);
    chk("sub_noborrow.bout", {8'd0, bout}, 9'd0);

    step(8'hA5, 8'hA5);
    chk("equal.diff", {1'b0, difference}, 9'd0);
    chk("equal.bout", {8'd0, bout}, 9'd0);
    chk("equal.xor", {1'b0, xor_output}, 9'd0);
    chk("equal.sum", {1'b0, sum}, 9'h04A);
    chk("equal.cout", {8'd0, cout}, 9'd1);

    step(8'd0, 8'd0);
    chk("zeros.sum", {1'b0, sum}, 9'd0);
    chk("zeros.cout", {8'd0, cout}, 9'd0);
    chk("zeros.diff", {1'b0, difference}, 9'd0);
    chk("zeros.bout", {8'd0, bout}, 9'd0);

    step(8'd255, 8'd1);
    chk("255p1.sum", {1'b0, sum}, 9'd0);
    chk("255p1.cout", {8'd0, cout}, 9'd1);

    step(8'd0, 8'd1);
    chk("0m1.diff", {1'b0, difference}, 9'd255);
    chk("0m1.bout", {8'd0, bout}, 9'd1);

`ifdef SIGNED_FLAGS_EN
    step(8'h7F, 8'h01);
    chk("flags_7f01.add_ovf", {8'd0, add_ovf}, 9'd1);
    chk("flags_7f01.sub_ovf", {8'd0, sub_ovf}, 9'd0);
    chk("flags_7f01.zero", {8'd0, zero}, 9'd0);

    step(8'h80, 8'h01);
    chk("flags_8001.sub_ovf", {8'd0, sub_ovf}, 9'd1);
    chk("flags_8001.add_ovf", {8'd0, add_ovf}, 9'd0);

    step(8'h80, 8'h80);
    chk("flags_8080.zero", {8'd0, zero}, 9'd1);
    chk("flags_8080.add_ovf", {8'd0, add_ovf}, 9'd1);
    chk("flags_8080.sub_ovf", {8'd0, sub_ovf}, 9'd0);
`endif

    // Exhaustive sweep with a reset pulse part way through.
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] v;
      v = i[15:0];
      step(v[15:8], v[7:0]);
      chk_all("sweep", v[15:8], v[7:0]);
      if (i == 30000) begin
        #2;
        rst = 1'b1;
        #1;
        chk_zero("sweep_rst");
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
